jedro_1_sig_mailbox: RTL and testbench

//  Synthesizable signature/halt mailbox for compliance runs. Bus responder on the core data interface:

---
 rtl/jedro_1_sig_mailbox_if.sv | 53 +++++
 rtl/jedro_1_sig_mailbox.sv | 145 ++++++++++++++
 tb/tb_jedro_1_sig_mailbox.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_sig_mailbox_if.sv
// Bus bundle for the signature mailbox: register slave port, data-RAM read
// master port and the signature output stream.
//
// Handshakes:
//   dram_*: request is a one-cycle dram_stb. Exactly one cycle later the
//           mailbox pulses dram_ack (dram_rdata valid) or dram_err, or gives
//           no response if the address is outside its window.
//   mrd_*:  mrd_stb/mrd_addr are held stable until mrd_ack. mrd_ack may
//           arrive in the same cycle mrd_stb rises. mrd_rdata is valid with
//           mrd_ack.
//   sig_*:  sig_valid/sig_data/sig_last are held stable until sig_ready. A
//           word transfers on a cycle where sig_valid && sig_ready.
interface jedro_1_sig_mailbox_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dram_stb;
  logic [3:0]            dram_we;
  logic [DATA_WIDTH-1:0] dram_addr;
  logic [DATA_WIDTH-1:0] dram_wdata;
  logic [DATA_WIDTH-1:0] dram_rdata;
  logic                  dram_ack;
  logic                  dram_err;

  logic                  mrd_stb;
  logic [DATA_WIDTH-1:0] mrd_addr;
  logic [DATA_WIDTH-1:0] mrd_rdata;
  logic                  mrd_ack;

  logic                  sig_valid;
  logic [DATA_WIDTH-1:0] sig_data;
  logic                  sig_last;
  logic                  sig_ready;

  // Mailbox side.
  modport slave (
    input  dram_stb, dram_we, dram_addr, dram_wdata,
    output dram_rdata, dram_ack, dram_err,
    output mrd_stb, mrd_addr,
    input  mrd_rdata, mrd_ack,
    output sig_valid, sig_data, sig_last,
    input  sig_ready
  );

  // Environment side: core, data RAM and signature sink.
  modport master (
    output dram_stb, dram_we, dram_addr, dram_wdata,
    input  dram_rdata, dram_ack, dram_err,
    input  mrd_stb, mrd_addr,
    output mrd_rdata, mrd_ack,
    input  sig_valid, sig_data, sig_last,
    output sig_ready
  );
endinterface

// File: rtl/jedro_1_sig_mailbox.sv
// Signature/halt mailbox. Software programs the signature window and writes
// HALT; the mailbox then reads every word of [START,END) from data RAM and
// streams it out, finally raising done_o (sticky until reset).
module jedro_1_sig_mailbox #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_FFF0
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  jedro_1_sig_mailbox_if.slave   bus,
  output logic                   halted_o,
  output logic                   done_o,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] start_q, end_q, ptr_q, data_q;
  logic                  halted_q, halt_go_q;
  logic                  busy;
  logic [DATA_WIDTH:0]   ptr_inc;
  logic                  last_beat;

  // Register window decode.
  logic                  sel, is_rd, is_wr, locked, req_err, wr_ok;
  logic [1:0]            reg_idx;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_bits;

  assign sel     = bus.dram_stb && (bus.dram_addr[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
  assign reg_idx = bus.dram_addr[3:2];
  assign is_rd   = (bus.dram_we == 4'b0000);
  assign is_wr   = (bus.dram_we == 4'b1111);
  // Once HALT is accepted the configuration is frozen; this also covers the
  // single cycle between the HALT ack and the FSM leaving IDLE.
  assign locked  = (state_q != S_IDLE) || halted_q;
  assign req_err = (!is_rd && !is_wr) || (is_wr && ((reg_idx == 2'd3) || locked));
  assign wr_ok   = sel && is_wr && !req_err;

  assign unused_bits = ^{bus.dram_addr[1:0], bus.dram_wdata[1]};

  // 33-bit increment so a pointer wrapping past the top counts as the end.
  assign ptr_inc   = {1'b0, ptr_q} + {{DATA_WIDTH{1'b0}}, 1'b0} + (DATA_WIDTH+1)'(4);
  assign last_beat = (ptr_inc >= {1'b0, end_q});
  assign busy      = (state_q == S_FETCH) || (state_q == S_SEND);

  // Register read mux; HALT reads as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      2'd0:    rd_mux = start_q;
      2'd1:    rd_mux = end_q;
      2'd2:    rd_mux = '0;
      default: rd_mux = {{(DATA_WIDTH-3){1'b0}}, done_o, busy, halted_q};
    endcase
  end

  // Slave response: one-cycle ack/err pulse after the sampled strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.dram_ack   <= 1'b0;
      bus.dram_err   <= 1'b0;
      bus.dram_rdata <= '0;
    end else begin
      bus.dram_ack   <= sel && !req_err;
      bus.dram_err   <= sel && req_err;
      bus.dram_rdata <= (sel && is_rd) ? rd_mux : '0;
    end
  end

  // Configuration registers and halt request; errored writes fall through.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_q   <= '0;
      end_q     <= '0;
      halted_q  <= 1'b0;
      halt_go_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && halt_go_q) halt_go_q <= 1'b0;
      if (wr_ok) begin
        case (reg_idx)
          2'd0: start_q <= {bus.dram_wdata[DATA_WIDTH-1:2], 2'b00};
          2'd1: end_q   <= {bus.dram_wdata[DATA_WIDTH-1:2], 2'b00};
          2'd2: if (bus.dram_wdata[0]) begin
            halted_q  <= 1'b1;
            halt_go_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  // Dump datapath: read pointer and captured RAM word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (halt_go_q) ptr_q <= start_q;
        S_FETCH: if (bus.mrd_ack) data_q <= bus.mrd_rdata;
        S_SEND:  if (bus.sig_ready) ptr_q <= ptr_inc[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // FSM next-state logic; an empty window goes straight to DONE.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (halt_go_q) state_n = (start_q < end_q) ? S_FETCH : S_DONE;
      S_FETCH: if (bus.mrd_ack) state_n = S_SEND;
      S_SEND:  if (bus.sig_ready) state_n = last_beat ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs; fetch and send are mutually exclusive by state.
  always_comb begin
    bus.mrd_stb   = (state_q == S_FETCH);
    bus.mrd_addr  = (state_q == S_FETCH) ? ptr_q : '0;
    bus.sig_valid = (state_q == S_SEND);
    bus.sig_data  = (state_q == S_SEND) ? data_q : '0;
    bus.sig_last  = (state_q == S_SEND) && last_beat;
    done_o        = (state_q == S_DONE);
    halted_o      = halted_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_jedro_1_sig_mailbox.sv
module tb_jedro_1_sig_mailbox;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] R_START = BASE + 32'h0;
  localparam logic [31:0] R_END = BASE + 32'h4;
  localparam logic [31:0] R_HALT = BASE + 32'h8;
  localparam logic [31:0] R_STAT = BASE + 32'hC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn_i;
  always #5 clk = ~clk;

  jedro_1_sig_mailbox_if #(.DATA_WIDTH(32)) bus ();
  logic       halted_o, done_o;
  logic [1:0] dbg_state;

  jedro_1_sig_mailbox dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .bus       (bus),
    .halted_o  (halted_o),
    .done_o    (done_o),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];                 // {last, data}
  logic [31:0] mem [logic [31:0]];
  int req_cnt, beat_cnt, wait_total;
  int addr_viol, stab_viol, excl_viol;
  int lat_first, lat_rest;
  int stall_beat, stall_left;
  bit hold_ready;

  function automatic void check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- data RAM model ----------------
  initial begin : ram_model
    bit pending;
    int wait_cnt, cur_lat;
    logic [31:0] hold_addr;
    pending = 0; wait_cnt = 0; cur_lat = 0; hold_addr = '0;
    bus.mrd_ack = 1'b0;
    bus.mrd_rdata = '0;
    forever begin
      @(negedge clk);
      if (rstn_i && bus.mrd_stb) begin
        if (!pending) begin
          pending = 1; wait_cnt = 0; hold_addr = bus.mrd_addr;
          req_cnt++;
          cur_lat = (req_cnt == 1) ? lat_first : lat_rest;
        end else if (bus.mrd_addr !== hold_addr) begin
          addr_viol++;
        end
        if (wait_cnt >= cur_lat) begin
          bus.mrd_ack = 1'b1;
          bus.mrd_rdata = mem.exists(bus.mrd_addr) ? mem[bus.mrd_addr] : 32'hBAD0_0000;
          pending = 0;
        end else begin
          bus.mrd_ack = 1'b0;
          bus.mrd_rdata = '0;
          wait_cnt++;
          wait_total++;
        end
      end else begin
        pending = 0;
        bus.mrd_ack = 1'b0;
        bus.mrd_rdata = '0;
      end
    end
  end

  // ---------------- sink driver ----------------
  initial begin : sink_driver
    bus.sig_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_ready) bus.sig_ready = 1'b0;
      else if (bus.sig_valid && beat_cnt == stall_beat && stall_left > 0) begin
        bus.sig_ready = 1'b0;
        stall_left--;
      end else bus.sig_ready = 1'b1;
    end
  end

  // ---------------- stream monitor / scoreboard ----------------
  initial begin : sink_monitor
    bit have_prev, prev_acc;
    logic [32:0] prev_word, got, exp;
    have_prev = 0; prev_acc = 0; prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        have_prev = 0;
      end else begin
        if (bus.sig_valid && bus.mrd_stb) excl_viol++;
        if (bus.sig_valid) begin
          got = {bus.sig_last, bus.sig_data};
          if (have_prev && !prev_acc && got !== prev_word) stab_viol++;
          if (bus.sig_ready) begin
            if (exp_q.size() == 0) begin
              check("beat_unexpected", got, 33'h0);
            end else begin
              exp = exp_q.pop_front();
              check("beat", got, exp);
            end
            beat_cnt++;
          end
          have_prev = 1; prev_acc = bus.sig_ready; prev_word = got;
        end else have_prev = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                            output logic ack, output logic err, output logic [31:0] rdata);
    @(posedge clk); #1;
    bus.dram_stb = 1'b1; bus.dram_addr = addr; bus.dram_we = we; bus.dram_wdata = wdata;
    @(posedge clk); #1;
    bus.dram_stb = 1'b0; bus.dram_we = 4'b0; bus.dram_wdata = '0;
    @(negedge clk);
    ack = bus.dram_ack; err = bus.dram_err; rdata = bus.dram_rdata;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
    logic a, e; logic [31:0] r;
    bus_access(addr, 4'hF, data, a, e, r);
    check(name, {a, e}, {!exp_err, exp_err});
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic a, e; logic [31:0] r;
    bus_access(addr, 4'h0, 32'h0, a, e, r);
    check(name, {a, e, r}, {1'b1, 1'b0, exp});
  endtask

  task automatic clear_env();
    exp_q.delete();
    mem.delete();
    req_cnt = 0; beat_cnt = 0; wait_total = 0;
    addr_viol = 0; stab_viol = 0; excl_viol = 0;
    lat_first = 0; lat_rest = 0;
    stall_beat = -1; stall_left = 0; hold_ready = 0;
  endtask

  task automatic reset_dut();
    rstn_i = 1'b0;
    bus.dram_stb = 1'b0; bus.dram_we = 4'b0; bus.dram_addr = '0; bus.dram_wdata = '0;
    clear_env();
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic load_words(input logic [31:0] start, input int n);
    logic [31:0] a, w;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      w = $urandom;
      mem[a] = w;
      exp_q.push_back({(i == n - 1), w});
    end
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check(name, done_o, 1'b1);
  endtask

  task automatic end_checks(input string tag, input int words);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_reqs"}, req_cnt, words);
    check({tag, "_beats"}, beat_cnt, words);
    check({tag, "_stable"}, stab_viol, 0);
    check({tag, "_exclusive"}, excl_viol, 0);
    check({tag, "_addr_hold"}, addr_viol, 0);
  endtask

  // ---------------- register access vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];

  initial begin : main
    logic a, e; logic [31:0] r;
    rstn_i = 1'b0;
    bus.dram_stb = 1'b0; bus.dram_we = 4'b0; bus.dram_addr = '0; bus.dram_wdata = '0;

    vecs[0]  = '{R_STAT,  4'h0, 32'h0,        1, 0, 32'h0};
    vecs[1]  = '{R_START, 4'hF, 32'h0000_0123, 1, 0, 32'h0};
    vecs[2]  = '{R_START, 4'h0, 32'h0,        1, 0, 32'h0000_0120};
    vecs[3]  = '{R_END,   4'hF, 32'h0002_0007, 1, 0, 32'h0};
    vecs[4]  = '{R_END,   4'h0, 32'h0,        1, 0, 32'h0002_0004};
    vecs[5]  = '{R_HALT,  4'h0, 32'h0,        1, 0, 32'h0};
    vecs[6]  = '{R_STAT,  4'hF, 32'hFFFF_FFFF, 0, 1, 32'h0};
    vecs[7]  = '{R_START, 4'h3, 32'h0000_DEAD, 0, 1, 32'h0};
    vecs[8]  = '{R_START, 4'h0, 32'h0,        1, 0, 32'h0000_0120};
    vecs[9]  = '{R_HALT,  4'hF, 32'h0000_0000, 1, 0, 32'h0};
    vecs[10] = '{R_STAT,  4'h0, 32'h0,        1, 0, 32'h0};
    vecs[11] = '{32'hFFFF_FFE0, 4'h0, 32'h0,  0, 0, 32'h0};
    vecs[12] = '{32'h0000_0100, 4'hF, 32'h1,  0, 0, 32'h0};
    vecs[13] = '{R_HALT,  4'h8, 32'h0000_0001, 0, 1, 32'h0};
    vecs[14] = '{R_STAT,  4'h0, 32'h0,        1, 0, 32'h0};

    // Reset state.
    reset_dut();
    @(negedge clk);
    check("rst_outputs", {halted_o, done_o, bus.mrd_stb, bus.sig_valid, bus.sig_last,
                          bus.dram_ack, bus.dram_err, dbg_state}, 33'h0);
    check("rst_rdata", bus.dram_rdata, 33'h0);

    // Register window, applied from the table.
    for (int i = 0; i < 15; i++) begin
      bus_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, a, e, r);
      check($sformatf("vec%0d_resp", i), {a, e, r}, {vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_rdata});
      @(negedge clk);
      check($sformatf("vec%0d_oneshot", i), {bus.dram_ack, bus.dram_err}, 2'b00);
    end
    check("vec_no_halt", {halted_o, dbg_state}, 3'b000);

    // 1: three-word dump, sink always ready.
    reset_dut();
    load_words(32'h100, 3);
    wr("t1_start", R_START, 32'h100, 0);
    wr("t1_end", R_END, 32'h10C, 0);
    wr("t1_halt", R_HALT, 32'h1, 0);
    check("t1_halted", halted_o, 1'b1);
    wait_done("t1_done", 200);
    end_checks("t1", 3);
    rd("t1_status", R_STAT, 32'h5);
    check("t1_state", dbg_state, 2'd3);

    // 2: empty window goes directly to DONE.
    reset_dut();
    wr("t2_start", R_START, 32'h200, 0);
    wr("t2_end", R_END, 32'h200, 0);
    wr("t2_halt", R_HALT, 32'h1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    check("t2_done_fast", done_o, 1'b1);
    end_checks("t2", 0);

    // 3+4: stalled beat 2 and rejected writes during the dump.
    reset_dut();
    load_words(32'h300, 4);
    stall_beat = 1; stall_left = 5;
    wr("t3_start", R_START, 32'h300, 0);
    wr("t3_end", R_END, 32'h310, 0);
    wr("t3_halt", R_HALT, 32'h1, 0);
    wr("t4_start_locked", R_START, 32'h0, 1);
    wr("t4_end_locked", R_END, 32'h0, 1);
    wait_done("t3_done", 300);
    end_checks("t3", 4);
    check("t3_stalled", stall_left, 0);
    rd("t4_start_kept", R_START, 32'h300);
    rd("t4_end_kept", R_END, 32'h310);

    // 5: slow first fetch, single-cycle second fetch.
    reset_dut();
    load_words(32'h400, 2);
    lat_first = 4; lat_rest = 0;
    wr("t5_start", R_START, 32'h400, 0);
    wr("t5_end", R_END, 32'h408, 0);
    wr("t5_halt", R_HALT, 32'h1, 0);
    wait_done("t5_done", 200);
    end_checks("t5", 2);
    check("t5_wait", wait_total, 4);

    // 6: async reset during SEND, then a fresh dump.
    reset_dut();
    load_words(32'h500, 4);
    hold_ready = 1;
    wr("t6_start", R_START, 32'h500, 0);
    wr("t6_end", R_END, 32'h510, 0);
    wr("t6_halt", R_HALT, 32'h1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sig_valid) break;
    end
    check("t6_in_send", bus.sig_valid, 1'b1);
    @(posedge clk); #2;
    rstn_i = 1'b0;
    #1;
    check("t6_async_outputs", {halted_o, done_o, bus.mrd_stb, bus.sig_valid, bus.sig_last,
                               bus.dram_ack, bus.dram_err, dbg_state}, 33'h0);
    check("t6_async_data", bus.sig_data, 33'h0);
    clear_env();
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    rd("t6_status_clear", R_STAT, 32'h0);
    rd("t6_start_clear", R_START, 32'h0);
    load_words(32'h600, 1);
    wr("t6b_start", R_START, 32'h600, 0);
    wr("t6b_end", R_END, 32'h604, 0);
    wr("t6b_halt", R_HALT, 32'h1, 0);
    wait_done("t6b_done", 100);
    end_checks("t6b", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
